// File: rtl/lfsr_decrypt_ctrl.sv
// lfsr_decrypt_ctrl
//   Fixed-function sequencer for the LFSR decryption flow. One run per launch:
//   buffers the ciphertext preamble, finds which of nine tap patterns produced
//   it, then decrypts MSG_LEN bytes from CT_BASE.. into address 0.. of the
//   single-port data memory and holds ack high until req is raised again.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   init_n     : asynchronous active-low reset
//   req        : high holds the block idle (and arms it); high->low launches a run
//   ack        : run complete (high in DONE)
//   err        : no tap pattern matched the preamble (valid with ack)
//   tap_idx    : index 0..8 of the matched tap pattern (valid with ack, !err)
//   mem_addr   : data-memory address
//   mem_wen    : data-memory write enable
//   mem_wdata  : data-memory write data
//   mem_rdata  : data-memory read data, one cycle after the address is sampled

module lfsr_decrypt_ctrl #(
   parameter int PRE_MIN = 10,
   parameter int MSG_LEN = 64,
   parameter int CT_BASE = 64
) (
   input  logic       clk,
   input  logic       init_n,
   input  logic       req,
   output logic       ack,
   output logic       err,
   output logic [3:0] tap_idx,
   output logic [7:0] mem_addr,
   output logic       mem_wen,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   localparam int LDW = $clog2(PRE_MIN + 1);

   typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DEC_RD, DEC_WR, DONE} state_t;

   state_t           state, state_nxt;
   logic             armed;
   logic [LDW-1:0]   ld_cnt;
   logic [3:0]       sidx;
   logic [6:0]       lfsr;
   logic [5:0]       cnt;
   logic [6:0]       b [PRE_MIN];
   logic             match;

   // Ciphertext bit 7 carries no information.
   logic             ct_msb_unused;
   assign ct_msb_unused = mem_rdata[7];

   function automatic logic [6:0] tap_of(input logic [3:0] i);
      case (i)
         4'd0:    tap_of = 7'h60;
         4'd1:    tap_of = 7'h48;
         4'd2:    tap_of = 7'h78;
         4'd3:    tap_of = 7'h72;
         4'd4:    tap_of = 7'h6A;
         4'd5:    tap_of = 7'h69;
         4'd6:    tap_of = 7'h5C;
         4'd7:    tap_of = 7'h7E;
         4'd8:    tap_of = 7'h7B;
         default: tap_of = 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] t);
      lfsr_next = {s[5:0], ^(s & t)};
   endfunction

   // State register.
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every always_ff sees the pre-edge value of every other register.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and memory-port outputs. Outputs are decoded from the current
   // state so that an asynchronous reset drops mem_wen immediately.
   // NOTE: every signal gets a default before the case, otherwise the
   // unassigned paths would infer latches.
   always_comb begin
      state_nxt = state;
      ack       = 1'b0;
      mem_addr  = 8'h00;
      mem_wen   = 1'b0;
      mem_wdata = 8'h00;

      // Candidate sidx explains the whole preamble if each buffered byte is
      // the LFSR successor of the one before it.
      match = 1'b1;
      for (int i = 0; i < PRE_MIN - 1; i++) begin
         if (lfsr_next(b[i], tap_of(sidx)) != b[i+1]) match = 1'b0;
      end

      case (state)
         IDLE: begin
            if (armed && !req) state_nxt = LOAD;
         end
         LOAD: begin
            // ld_cnt == PRE_MIN is the extra cycle that captures the last byte.
            if (ld_cnt < LDW'(PRE_MIN)) mem_addr = 8'(CT_BASE) + 8'(ld_cnt);
            if (ld_cnt == LDW'(PRE_MIN)) state_nxt = SEARCH;
         end
         SEARCH: begin
            if (match)              state_nxt = DEC_RD;
            else if (sidx == 4'd8)  state_nxt = DONE;
         end
         DEC_RD: begin
            mem_addr  = 8'(CT_BASE) + {2'b00, cnt};
            state_nxt = DEC_WR;
         end
         DEC_WR: begin
            mem_addr  = {2'b00, cnt};
            mem_wen   = 1'b1;
            mem_wdata = {1'b0, mem_rdata[6:0] ^ lfsr};
            if (cnt == 6'(MSG_LEN - 1)) state_nxt = DONE;
            else                        state_nxt = DEC_RD;
         end
         DONE: begin
            ack = 1'b1;
            if (req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         armed   <= 1'b0;
         err     <= 1'b0;
         tap_idx <= 4'd0;
         ld_cnt  <= '0;
         sidx    <= 4'd0;
         lfsr    <= 7'h00;
         cnt     <= 6'd0;
      end else begin
         case (state)
            IDLE: begin
               if (armed && !req) begin
                  // Launch: previous results are discarded here.
                  armed   <= 1'b0;
                  err     <= 1'b0;
                  tap_idx <= 4'd0;
                  ld_cnt  <= '0;
                  sidx    <= 4'd0;
               end else if (req) begin
                  armed <= 1'b1;
               end
            end
            LOAD: begin
               if (ld_cnt != LDW'(PRE_MIN)) ld_cnt <= ld_cnt + 1'b1;
            end
            SEARCH: begin
               if (match) begin
                  tap_idx <= sidx;
                  lfsr    <= b[0];
                  cnt     <= 6'd0;
               end else if (sidx == 4'd8) begin
                  err <= 1'b1;
               end else begin
                  sidx <= sidx + 4'd1;
               end
            end
            DEC_WR: begin
               lfsr <= lfsr_next(lfsr, tap_of(tap_idx));
               cnt  <= cnt + 6'd1;
            end
            DONE: begin
               if (req) armed <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Preamble buffer. Byte for address CT_BASE+i arrives while ld_cnt == i+1.
   // NOTE: the buffer is deliberately left without reset; it is always fully
   // rewritten in LOAD before SEARCH reads it, and a reset would stop it
   // mapping onto plain storage.
   always_ff @(posedge clk) begin
      if (state == LOAD && ld_cnt != '0) b[ld_cnt - 1'b1] <= mem_rdata[6:0];
   end

endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
// Self-checking bench for lfsr_decrypt_ctrl: behavioural memory, a
// specification-level model of each run (tap search, expected plaintext,
// write schedule, ack time) and one per-cycle compare process.

module tb_lfsr_decrypt_ctrl;

   localparam int PRE_MIN = 10;
   localparam logic [6:0] TAPS [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                         7'h69, 7'h5C, 7'h7E, 7'h7B};

   logic       clk = 1'b0;
   logic       init_n;
   logic       req;
   logic       ack;
   logic       err;
   logic [3:0] tap_idx;
   logic [7:0] mem_addr;
   logic       mem_wen;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   lfsr_decrypt_ctrl dut (
      .clk       (clk),
      .init_n    (init_n),
      .req       (req),
      .ack       (ack),
      .err       (err),
      .tap_idx   (tap_idx),
      .mem_addr  (mem_addr),
      .mem_wen   (mem_wen),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port synchronous-read memory; tb_load copies img in one edge.
   logic [7:0] mem [0:255];
   logic [7:0] img [0:255];
   logic       tb_load = 1'b0;

   always @(posedge clk) begin
      if (tb_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else begin
         mem_rdata <= mem[mem_addr];
         if (mem_wen) mem[mem_addr] <= mem_wdata;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] msg_pad [0:63];
   logic [7:0] exp_pt  [0:63];
   int         exp_idx;
   bit         exp_err;
   int         ack_edge;

   function automatic logic [6:0] step7(input logic [6:0] s, input logic [6:0] t);
      return {s[5:0], ^(s & t)};
   endfunction

   // Plaintext is the space-offset message; ciphertext = offset byte ^ LFSR
   // state, with a random bit 7 that must be ignored.
   task automatic gen_ct(input int t, input logic [6:0] init, input bit watson);
      string      w;
      logic [6:0] s;
      logic [7:0] m;
      w = "Mr. Watson, come here. I want to see you.";
      s = init;
      for (int n = 0; n < 64; n++) begin
         img[n] = 8'($urandom);
         if (n < PRE_MIN)                  m = 8'h20;
         else if (watson && n - 10 < w.len()) m = w[n-10];
         else if (watson)                  m = 8'h20;
         else                              m = 8'($urandom_range(32, 126));
         msg_pad[n] = m;
         img[64+n] = {1'($urandom), 7'(m - 8'h20) ^ s};
         s = step7(s, TAPS[t]);
      end
   endtask

   task automatic model_run();
      logic [6:0] bb [PRE_MIN];
      logic [6:0] s;
      bit         ok;
      for (int i = 0; i < PRE_MIN; i++) bb[i] = img[64+i][6:0];
      exp_err = 1'b1;
      exp_idx = 0;
      for (int t = 0; t < 9; t++) begin
         if (exp_err) begin
            ok = 1'b1;
            for (int i = 0; i < PRE_MIN - 1; i++)
               if (step7(bb[i], TAPS[t]) != bb[i+1]) ok = 1'b0;
            if (ok) begin
               exp_err = 1'b0;
               exp_idx = t;
            end
         end
      end
      s = bb[0];
      for (int j = 0; j < 64; j++) begin
         exp_pt[j] = {1'b0, img[64+j][6:0] ^ s};
         s = step7(s, TAPS[exp_idx]);
      end
      ack_edge = exp_err ? 20 : 140 + exp_idx;
   endtask

   // ---------------- per-cycle compare ----------------
   bit run_active = 1'b0;
   int launch_edge;
   int ack_seen;
   int wen_count;
   int cmp_n, cmp_k, cmp_j;
   bit wexp;

   always @(negedge clk) begin
      if (run_active) begin
         cmp_n = cyc - launch_edge;
         cmp_k = exp_idx;
         if (ack && ack_seen < 0) ack_seen = cmp_n;
         if (mem_wen) wen_count++;
         check("ack", ack, cmp_n >= ack_edge);
         if (cmp_n >= ack_edge) check("err", err, exp_err);
         else                   check("err_pre", err, 0);
         if (!exp_err) check("tap_idx", tap_idx, (cmp_n >= 12 + cmp_k) ? cmp_k : 0);
         else          check("tap_idx_err", tap_idx, 0);
         wexp = !exp_err && cmp_n >= 13 + cmp_k && cmp_n <= 139 + cmp_k &&
                ((cmp_n - 13 - cmp_k) % 2 == 0);
         check("mem_wen", mem_wen, wexp);
         if (wexp && mem_wen) begin
            cmp_j = (cmp_n - 13 - cmp_k) / 2;
            check("wr_addr", mem_addr, cmp_j);
            check("wr_data", mem_wdata, exp_pt[cmp_j]);
         end
      end
   end

   // ---------------- sequencing helpers ----------------
   task automatic load_mem();
      @(negedge clk) tb_load = 1'b1;
      @(negedge clk) tb_load = 1'b0;
   endtask

   task automatic launch(input bit check_fall);
      @(negedge clk) req = 1'b1;
      @(posedge clk);
      #1;
      if (check_fall) check("ack_fall", ack, 0);
      @(negedge clk) req = 1'b0;
      @(posedge clk);
      #1;
      ack_seen    = -1;
      wen_count   = 0;
      launch_edge = cyc;
      run_active  = 1'b1;
   endtask

   task automatic wait_run();
      repeat (ack_edge + 2) @(posedge clk);
      #2;
      run_active = 1'b0;
   endtask

   task automatic final_mem(input string name);
      int bad;
      bad = 0;
      for (int j = 0; j < 64; j++)
         if (mem[j] !== (exp_err ? img[j] : exp_pt[j])) bad++;
      check(name, bad, 0);
   endtask

   logic [6:0] inits [0:2] = '{7'h01, 7'h7F, 7'h35};

   initial begin
      int viol;
      init_n = 1'b0;
      req    = 1'b1;
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      load_mem();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", ack, 0);
      check("rst_err", err, 0);
      check("rst_tap", tap_idx, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wen", mem_wen, 0);
      check("rst_wdata", mem_wdata, 0);
      @(negedge clk) init_n = 1'b1;

      // req held high: block must stay idle.
      viol = 0;
      repeat (200) @(negedge clk) if (ack || mem_wen || mem_addr != 8'h00) viol++;
      check("idle_hold", viol, 0);

      // Known message, tap 6, init 0x35.
      gen_ct(6, 7'h35, 1'b1);
      load_mem();
      model_run();
      launch(1'b0);
      wait_run();
      check("watson_latency", ack_seen, 146);
      check("watson_tap", tap_idx, 6);
      check("watson_err", err, 0);
      check("watson_mem0", mem[0], 8'h00);
      check("watson_mem9", mem[9], 8'h00);
      check("watson_mem10", mem[10], 8'h2D);
      viol = 0;
      for (int n = 10; n < 64; n++) if (8'(mem[n] + 8'h20) !== msg_pad[n]) viol++;
      check("watson_msg", viol, 0);
      check("watson_wen_count", wen_count, 64);
      final_mem("watson_model_mem");

      // Preamble no tap can produce.
      for (int n = 0; n < 128; n++) img[n] = 8'($urandom);
      img[64] = 8'h01; img[65] = 8'h02; img[66] = 8'h04; img[67] = 8'h08;
      img[68] = 8'h10; img[69] = 8'h20; img[70] = 8'h40; img[71] = 8'h7F;
      img[72] = 8'h00; img[73] = 8'h55;
      load_mem();
      model_run();
      launch(1'b1);
      wait_run();
      check("err_latency", ack_seen, 20);
      check("err_flag", err, 1);
      check("err_wen_count", wen_count, 0);
      final_mem("err_mem_unchanged");

      // Sweep every tap with several start states, back to back.
      for (int t = 0; t < 9; t++) begin
         for (int s = 0; s < 3; s++) begin
            gen_ct(t, inits[s], 1'b0);
            load_mem();
            model_run();
            launch(1'b1);
            wait_run();
            check("sweep_gen_idx", tap_idx, t);
            check("sweep_latency", ack_seen, 140 + t);
            check("sweep_wen_count", wen_count, 64);
            viol = 0;
            for (int n = 0; n < 64; n++) if (8'(mem[n] + 8'h20) !== msg_pad[n]) viol++;
            check("sweep_msg", viol, 0);
            final_mem("sweep_model_mem");
         end
      end

      // Reset in the write cycle of byte 30, then relaunch.
      gen_ct(3, 7'h35, 1'b0);
      load_mem();
      model_run();
      launch(1'b1);
      repeat (73 + exp_idx) @(posedge clk);
      #2;
      run_active = 1'b0;
      check("pre_rst_wen", mem_wen, 1);
      check("pre_rst_addr", mem_addr, 30);
      init_n = 1'b0;
      #1;
      check("mid_rst_wen", mem_wen, 0);
      check("mid_rst_ack", ack, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_tap", tap_idx, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_wdata", mem_wdata, 0);
      @(negedge clk) init_n = 1'b1;
      check("write_before_rst", mem[29], exp_pt[29]);
      check("no_write_after_rst", mem[30], img[30]);
      launch(1'b0);
      wait_run();
      check("relaunch_latency", ack_seen, 140 + exp_idx);
      final_mem("relaunch_mem");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
